// File: rtl/branch_if.sv
// Branch request / PC-load bundle between the issue stage and branch_unit.
//   master : the requester. It drives br_valid, br_cond, br_target,
//            br_value, pc_cur and stats_clr, and samples the results.
//   slave  : branch_unit. It drives br_ready, pc_load, pc_target,
//            link_addr, flush, taken_cnt and nottaken_cnt.
interface branch_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_cond;
  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] br_value;
  logic [DATA_W-1:0] pc_cur;
  logic              pc_load;
  logic [DATA_W-1:0] pc_target;
  logic [DATA_W-1:0] link_addr;
  logic              flush;
  logic              stats_clr;
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  nottaken_cnt;

  modport master (
    output br_valid, br_cond, br_target, br_value, pc_cur, stats_clr,
    input  br_ready, pc_load, pc_target, link_addr, flush, taken_cnt, nottaken_cnt
  );

  modport slave (
    input  br_valid, br_cond, br_target, br_value, pc_cur, stats_clr,
    output br_ready, pc_load, pc_target, link_addr, flush, taken_cnt, nottaken_cnt
  );
endinterface

// File: rtl/branch_unit.sv
// Registered branch-resolution unit.
// A request is accepted over br_valid/br_ready and held for one EVAL cycle,
// where the operand is compared against ANCHOR under one of eight condition
// codes. A taken branch produces a one-cycle pc_load pulse with the target
// and link address, followed by FLUSH_CYCLES cycles of flush. Saturating
// taken / not-taken counters are kept and can be cleared with stats_clr.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : branch_if slave modport (handshake, operands, PC-load, flush,
//            statistics)
module branch_unit #(
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] ANCHOR       = DATA_W'(8'hF0),
  parameter bit                SIGNED_CMP   = 1'b0,
  parameter int                FLUSH_CYCLES = 2,
  parameter int                CNT_W        = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  branch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e            state_q, state_d;
  logic [2:0]        cond_q, cond_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic              pc_load_q, pc_load_d;
  logic [DATA_W-1:0] pc_target_q, pc_target_d;
  logic [DATA_W-1:0] link_q, link_d;
  logic [CNT_W-1:0]  taken_q, taken_d;
  logic [CNT_W-1:0]  nottaken_q, nottaken_d;
  logic              taken;
  logic              accept;

  // Both operands are widened by one bit so a single signed comparison
  // serves both modes: sign-extend for signed, zero-extend for unsigned.
  function automatic logic cond_met(input logic [2:0]        c,
                                    input logic [DATA_W-1:0] v);
    logic signed [DATA_W:0] v_ext;
    logic signed [DATA_W:0] a_ext;
    logic                   eq;
    logic                   lt;
    v_ext    = SIGNED_CMP ? {v[DATA_W-1], v} : {1'b0, v};
    a_ext    = SIGNED_CMP ? {ANCHOR[DATA_W-1], ANCHOR} : {1'b0, ANCHOR};
    eq       = (v == ANCHOR);
    lt       = (v_ext < a_ext);
    cond_met = 1'b0;
    case (c)
      3'd0:    cond_met = 1'b0;
      3'd1:    cond_met = eq;
      3'd2:    cond_met = lt;
      3'd3:    cond_met = lt || eq;
      3'd4:    cond_met = 1'b1;
      3'd5:    cond_met = !eq;
      3'd6:    cond_met = !lt;
      3'd7:    cond_met = !(lt || eq);
      default: cond_met = 1'b0;
    endcase
  endfunction

  assign taken  = cond_met(cond_q, value_q);
  assign accept = bus.br_valid && (state_q == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EVAL;
      EVAL:    state_d = (taken && (FLUSH_CYCLES != 0)) ? FLUSH : IDLE;
      // Leave on the last flush cycle; <= also covers a stray zero count.
      FLUSH:   if (fcnt_q <= 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.br_ready = (state_q == IDLE);
    bus.flush    = (state_q == FLUSH);
  end

  // Operand capture, resolution results, flush counter and statistics
  always_comb begin
    cond_d      = cond_q;
    target_d    = target_q;
    value_d     = value_q;
    pc_d        = pc_q;
    fcnt_d      = fcnt_q;
    pc_load_d   = 1'b0;
    pc_target_d = pc_target_q;
    link_d      = link_q;
    taken_d     = taken_q;
    nottaken_d  = nottaken_q;

    if (accept) begin
      cond_d   = bus.br_cond;
      target_d = bus.br_target;
      value_d  = bus.br_value;
      pc_d     = bus.pc_cur;
    end

    if (state_q == FLUSH) fcnt_d = fcnt_q - 4'd1;

    if (state_q == EVAL) begin
      if (taken) begin
        pc_load_d   = 1'b1;
        pc_target_d = target_q;
        link_d      = pc_q + DATA_W'(1);
        fcnt_d      = FLUSH_INIT;
        if (taken_q != CNT_MAX) taken_d = taken_q + CNT_W'(1);
      end else if (nottaken_q != CNT_MAX) begin
        nottaken_d = nottaken_q + CNT_W'(1);
      end
    end

    // Clear takes priority over a same-edge increment.
    if (bus.stats_clr) begin
      taken_d    = '0;
      nottaken_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q      <= '0;
      target_q    <= '0;
      value_q     <= '0;
      pc_q        <= '0;
      fcnt_q      <= '0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
      link_q      <= '0;
      taken_q     <= '0;
      nottaken_q  <= '0;
    end else begin
      cond_q      <= cond_d;
      target_q    <= target_d;
      value_q     <= value_d;
      pc_q        <= pc_d;
      fcnt_q      <= fcnt_d;
      pc_load_q   <= pc_load_d;
      pc_target_q <= pc_target_d;
      link_q      <= link_d;
      taken_q     <= taken_d;
      nottaken_q  <= nottaken_d;
    end
  end

  assign bus.pc_load      = pc_load_q;
  assign bus.pc_target    = pc_target_q;
  assign bus.link_addr    = link_q;
  assign bus.taken_cnt    = taken_q;
  assign bus.nottaken_cnt = nottaken_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit. Four instances cover the parameter
// corners: u0 defaults, u1 signed compares, u2 no flush state, u3 2-bit
// counters. All outputs are sampled on the falling edge.
module tb_branch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] vld = '0;
  logic [3:0] clr = '0;
  logic [2:0] cond_r = '0;
  logic [7:0] target_r = '0;
  logic [7:0] value_r = '0;
  logic [7:0] pc_r = '0;

  logic [3:0]  rdy, pl, fl;
  logic [7:0]  tgt [4];
  logic [7:0]  lnk [4];
  logic [15:0] tc  [4];
  logic [15:0] ntc [4];

  int errors = 0;
  int checks = 0;
  int exp_t [2];
  int exp_nt[2];
  logic [7:0] sweep_v [6] = '{8'hEF, 8'hF0, 8'hF1, 8'h05, 8'h7F, 8'h80};

  always #5 clk = ~clk;

  branch_if #(.DATA_W(8), .CNT_W(16)) if0 ();
  branch_if #(.DATA_W(8), .CNT_W(16)) if1 ();
  branch_if #(.DATA_W(8), .CNT_W(16)) if2 ();
  branch_if #(.DATA_W(8), .CNT_W(2))  if3 ();

  branch_unit #(.SIGNED_CMP(1'b0), .FLUSH_CYCLES(2), .CNT_W(16))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  branch_unit #(.SIGNED_CMP(1'b1), .FLUSH_CYCLES(2), .CNT_W(16))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  branch_unit #(.SIGNED_CMP(1'b0), .FLUSH_CYCLES(0), .CNT_W(16))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  branch_unit #(.SIGNED_CMP(1'b0), .FLUSH_CYCLES(2), .CNT_W(2))
    u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if0.br_valid = vld[0];  assign if0.stats_clr = clr[0];
  assign if1.br_valid = vld[1];  assign if1.stats_clr = clr[1];
  assign if2.br_valid = vld[2];  assign if2.stats_clr = clr[2];
  assign if3.br_valid = vld[3];  assign if3.stats_clr = clr[3];
  assign if0.br_cond = cond_r;   assign if1.br_cond = cond_r;
  assign if2.br_cond = cond_r;   assign if3.br_cond = cond_r;
  assign if0.br_target = target_r; assign if1.br_target = target_r;
  assign if2.br_target = target_r; assign if3.br_target = target_r;
  assign if0.br_value = value_r; assign if1.br_value = value_r;
  assign if2.br_value = value_r; assign if3.br_value = value_r;
  assign if0.pc_cur = pc_r;      assign if1.pc_cur = pc_r;
  assign if2.pc_cur = pc_r;      assign if3.pc_cur = pc_r;

  assign rdy = {if3.br_ready, if2.br_ready, if1.br_ready, if0.br_ready};
  assign pl  = {if3.pc_load,  if2.pc_load,  if1.pc_load,  if0.pc_load};
  assign fl  = {if3.flush,    if2.flush,    if1.flush,    if0.flush};
  assign tgt[0] = if0.pc_target; assign tgt[1] = if1.pc_target;
  assign tgt[2] = if2.pc_target; assign tgt[3] = if3.pc_target;
  assign lnk[0] = if0.link_addr; assign lnk[1] = if1.link_addr;
  assign lnk[2] = if2.link_addr; assign lnk[3] = if3.link_addr;
  assign tc[0]  = if0.taken_cnt; assign tc[1] = if1.taken_cnt;
  assign tc[2]  = if2.taken_cnt; assign tc[3] = {14'd0, if3.taken_cnt};
  assign ntc[0] = if0.nottaken_cnt; assign ntc[1] = if1.nottaken_cnt;
  assign ntc[2] = if2.nottaken_cnt; assign ntc[3] = {14'd0, if3.nottaken_cnt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference compare against ANCHOR = 8'hF0 (240 unsigned, -16 signed).
  function automatic logic model_taken(input logic [2:0] c, input logic [7:0] v, input bit sgn);
    int vi;
    int ai;
    vi = sgn ? int'($signed(v)) : int'(v);
    ai = sgn ? -16 : 240;
    case (c)
      3'd0: return 1'b0;
      3'd1: return vi == ai;
      3'd2: return vi < ai;
      3'd3: return vi <= ai;
      3'd4: return 1'b1;
      3'd5: return vi != ai;
      3'd6: return vi >= ai;
      default: return vi > ai;
    endcase
  endfunction

  // Called at a falling edge; returns 1 time unit after the accept edge.
  task automatic send(input int d, input logic [2:0] c, input logic [7:0] t,
                      input logic [7:0] v, input logic [7:0] p);
    int n = 0;
    while (rdy[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("send_ready_u%0d", d), 32'(n < 20), 32'd1);
    cond_r = c; target_r = t; value_r = v; pc_r = p;
    vld[d] = 1'b1;
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    @(negedge clk);
    while (rdy[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_timeout_u%0d", d), 32'(n < 20), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    repeat (3) @(negedge clk);
    check("rst_pl", 32'(pl), 32'h0);
    check("rst_fl", 32'(fl), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'hF);
    check("rst_tc0", 32'(tc[0]), 32'h0);

    // Taken, two flush cycles
    send(0, 3'd1, 8'h3C, 8'hF0, 8'h10);
    @(negedge clk);
    check("tk_eval_rdy", 32'(rdy[0]), 32'h0);
    check("tk_eval_pl", 32'(pl[0]), 32'h0);
    @(negedge clk);
    check("tk_pl", 32'(pl[0]), 32'h1);
    check("tk_fl1", 32'(fl[0]), 32'h1);
    check("tk_tgt", 32'(tgt[0]), 32'h3C);
    check("tk_lnk", 32'(lnk[0]), 32'h11);
    check("tk_cnt", 32'(tc[0]), 32'h1);
    @(negedge clk);
    check("tk_pl_off", 32'(pl[0]), 32'h0);
    check("tk_fl2", 32'(fl[0]), 32'h1);
    check("tk_rdy_busy", 32'(rdy[0]), 32'h0);
    @(negedge clk);
    check("tk_fl_end", 32'(fl[0]), 32'h0);
    check("tk_rdy_back", 32'(rdy[0]), 32'h1);

    // Not taken, unsigned 0x80 > 0xF0 is false
    send(0, 3'd7, 8'h99, 8'h80, 8'h20);
    @(negedge clk);
    check("nt_eval_rdy", 32'(rdy[0]), 32'h0);
    check("nt_eval_fl", 32'(fl[0]), 32'h0);
    @(negedge clk);
    check("nt_rdy", 32'(rdy[0]), 32'h1);
    check("nt_pl", 32'(pl[0]), 32'h0);
    check("nt_fl", 32'(fl[0]), 32'h0);
    check("nt_cnt", 32'(ntc[0]), 32'h1);
    check("nt_tgt_hold", 32'(tgt[0]), 32'h3C);
    check("nt_lnk_hold", 32'(lnk[0]), 32'h11);
    exp_t[0] = 1; exp_nt[0] = 1;

    // Signed compare against -16
    send(1, 3'd2, 8'h44, 8'h05, 8'h30);
    @(negedge clk);
    @(negedge clk);
    check("sg_05_pl", 32'(pl[1]), 32'h0);
    check("sg_05_ntc", 32'(ntc[1]), 32'h1);
    send(1, 3'd2, 8'h66, 8'hE0, 8'h40);
    @(negedge clk);
    @(negedge clk);
    check("sg_E0_pl", 32'(pl[1]), 32'h1);
    check("sg_E0_tgt", 32'(tgt[1]), 32'h66);
    check("sg_E0_lnk", 32'(lnk[1]), 32'h41);
    wait_ready(1);
    exp_t[1] = 1; exp_nt[1] = 1;

    // Condition-code sweep on the unsigned and signed instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 6; i++) begin
        for (int c = 0; c < 8; c++) begin
          logic e;
          e = model_taken(3'(c), sweep_v[i], d == 1);
          send(d, 3'(c), 8'hA0 + 8'(c), sweep_v[i], 8'h50);
          @(negedge clk);
          @(negedge clk);
          check($sformatf("sweep_u%0d_c%0d_v%0h", d, c, sweep_v[i]), 32'(pl[d]), 32'(e));
          if (e) exp_t[d]++;
          else   exp_nt[d]++;
          wait_ready(d);
        end
      end
      check($sformatf("sweep_tc_u%0d", d), 32'(tc[d]), 32'(exp_t[d]));
      check($sformatf("sweep_ntc_u%0d", d), 32'(ntc[d]), 32'(exp_nt[d]));
    end

    // Asynchronous reset in the middle of FLUSH
    send(0, 3'd4, 8'h77, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("rf_pre_pl", 32'(pl[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rf_pl", 32'(pl[0]), 32'h0);
    check("rf_fl", 32'(fl[0]), 32'h0);
    check("rf_tgt", 32'(tgt[0]), 32'h0);
    check("rf_lnk", 32'(lnk[0]), 32'h0);
    check("rf_tc", 32'(tc[0]), 32'h0);
    check("rf_ntc", 32'(ntc[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rf_rdy", 32'(rdy[0]), 32'h1);
    check("rf_fl_after", 32'(fl[0]), 32'h0);

    // Asynchronous reset in EVAL: no pulse may follow
    send(0, 3'd4, 8'h88, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("re_rdy", 32'(rdy[0]), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("re_pl", 32'(pl[0]), 32'h0);
    check("re_tc", 32'(tc[0]), 32'h0);
    check("re_tgt", 32'(tgt[0]), 32'h0);

    // No flush state, link wrap, back-to-back accept in the pulse cycle
    send(2, 3'd4, 8'h55, 8'h00, 8'hFF);
    @(negedge clk);
    check("f0_eval_rdy", 32'(rdy[2]), 32'h0);
    @(negedge clk);
    check("f0_pl", 32'(pl[2]), 32'h1);
    check("f0_fl", 32'(fl[2]), 32'h0);
    check("f0_rdy", 32'(rdy[2]), 32'h1);
    check("f0_lnk", 32'(lnk[2]), 32'h00);
    check("f0_tgt", 32'(tgt[2]), 32'h55);
    check("f0_tc", 32'(tc[2]), 32'h1);
    send(2, 3'd0, 8'h11, 8'h00, 8'h20);
    @(negedge clk);
    check("f0_b2b_rdy", 32'(rdy[2]), 32'h0);
    check("f0_b2b_pl", 32'(pl[2]), 32'h0);
    check("f0_b2b_fl", 32'(fl[2]), 32'h0);
    @(negedge clk);
    check("f0_b2b_ntc", 32'(ntc[2]), 32'h1);
    check("f0_b2b_tgt", 32'(tgt[2]), 32'h55);
    check("f0_b2b_fl2", 32'(fl[2]), 32'h0);

    // Two-bit counters: saturation and clear-beats-increment
    send(3, 3'd0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("sat_ntc1", 32'(ntc[3]), 32'h1);
    for (int i = 0; i < 5; i++) begin
      send(3, 3'd4, 8'h30, 8'h00, 8'h00);
      @(negedge clk);
      @(negedge clk);
      check($sformatf("sat_tc_%0d", i), 32'(tc[3]), (i >= 2) ? 32'd3 : 32'(i + 1));
      wait_ready(3);
    end
    send(3, 3'd5, 8'h30, 8'hF0, 8'h00);
    @(negedge clk);
    clr[3] = 1'b1;
    @(posedge clk);
    #1;
    clr[3] = 1'b0;
    @(negedge clk);
    check("clr_ntc", 32'(ntc[3]), 32'h0);
    check("clr_tc", 32'(tc[3]), 32'h0);
    check("clr_rdy", 32'(rdy[3]), 32'h1);
    check("clr_pl", 32'(pl[3]), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
